// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the write-port arbiter slice.
package rf_pkg;

    localparam int unsigned RF_ADDR_W = 4;
    localparam int unsigned RF_DATA_W = 32;
    localparam logic [RF_ADDR_W-1:0] RF_PC_ADDR = 4'hF;

    // One write-stage entry headed for the register file's port A
    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wrCmd_t;

    // True when a live write targets the given read address
    function automatic logic addrHit(input logic                 wrValid,
                                     input logic [RF_ADDR_W-1:0] wrAddr,
                                     input logic [RF_ADDR_W-1:0] rdAddr);
        return wrValid && (wrAddr == rdAddr);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Parameterised N-way round-robin grant with a last-grant pointer.
// The scan starts one past the last granted index; pointer moves only on advance.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] reqVec,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] lastGrant;
    logic [IDX_W-1:0] grantIdx;
    logic             found;
    int unsigned      idx;

    // First requester after the pointer wins; at most one grant bit set
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(lastGrant) + k) % N;
            if (!found && reqVec[IDX_W'(idx)]) begin
                found                = 1'b1;
                grant[IDX_W'(idx)]   = 1'b1;
                grantIdx             = IDX_W'(idx);
            end
        end
    end

    // Pointer resets to N-1 so index 0 has first priority
    always_ff @(posedge clk) begin
        if (rst) begin
            lastGrant <= IDX_W'(N - 1);
        end else if (advance && found) begin
            lastGrant <= grantIdx;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin sharing of the register file's single write port (port A).
// A granted request is staged for one cycle, then written through port A while
// reads of the same address are bypassed and other port-A reads stall.
// Optional feature macro: RF_ARB_PC_PRIORITY_EN (writes to R15 jump the queue).
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned N_REQ = 3
) (
    input  logic                         CLK,
    input  logic                         CLR,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [RF_ADDR_W*N_REQ-1:0]   req_addr,
    input  logic [RF_DATA_W*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]             req_ready,
    input  logic                         rd_valid_a,
    input  logic [RF_ADDR_W-1:0]         rd_addr_a,
    input  logic [RF_ADDR_W-1:0]         rd_addr_b,
    output logic [RF_DATA_W-1:0]         rd_data_a,
    output logic [RF_DATA_W-1:0]         rd_data_b,
    output logic                         rd_stall_a,
    output logic [RF_ADDR_W-1:0]         rf_addressA,
    output logic [RF_ADDR_W-1:0]         rf_addressB,
    output logic [RF_DATA_W-1:0]         rf_inputData,
    output logic                         rf_RW,
    input  logic [RF_DATA_W-1:0]         rf_outA,
    input  logic [RF_DATA_W-1:0]         rf_outB
);

    logic [N_REQ-1:0]     rrGrant;
    logic [N_REQ-1:0]     grantVec;
    logic                 rrAdvance;
    logic                 accept;
    logic [RF_ADDR_W-1:0] selAddr;
    logic [RF_DATA_W-1:0] selData;
    wrCmd_t               wrCmd;
    logic                 effValid;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rrArbiter (
        .clk     (CLK),
        .rst     (CLR),
        .reqVec  (req_valid),
        .advance (rrAdvance),
        .grant   (rrGrant)
    );

`ifdef RF_ARB_PC_PRIORITY_EN
    logic [N_REQ-1:0] pcGrant;
    logic             pcFound;

    // Lowest-index request to R15 overrides round-robin without moving the pointer
    always_comb begin
        pcGrant = '0;
        pcFound = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!pcFound && req_valid[i] &&
                (req_addr[i*RF_ADDR_W +: RF_ADDR_W] == RF_PC_ADDR)) begin
                pcFound    = 1'b1;
                pcGrant[i] = 1'b1;
            end
        end
        grantVec  = pcFound ? pcGrant : rrGrant;
        rrAdvance = !pcFound;
    end
`else
    // Pure round-robin grant
    always_comb begin
        grantVec  = rrGrant;
        rrAdvance = 1'b1;
    end
`endif

    assign req_ready = grantVec;
    assign accept    = |grantVec;

    // One-hot select of the granted requester's address and data
    always_comb begin
        selAddr = '0;
        selData = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grantVec[i]) begin
                selAddr = selAddr | req_addr[i*RF_ADDR_W +: RF_ADDR_W];
                selData = selData | req_data[i*RF_DATA_W +: RF_DATA_W];
            end
        end
    end

    // Write stage; anything accepted during CLR is dropped
    always_ff @(posedge CLK) begin
        if (CLR) begin
            wrCmd <= '0;
        end else begin
            wrCmd.valid <= accept;
            if (accept) begin
                wrCmd.addr <= selAddr;
                wrCmd.data <= selData;
            end
        end
    end

    // A staged entry is discarded (never written) if CLR arrives while it is pending
    assign effValid = wrCmd.valid && !CLR;

    assign rf_RW        = effValid;
    assign rf_addressA  = effValid ? wrCmd.addr : rd_addr_a;
    assign rf_addressB  = rd_addr_b;
    assign rf_inputData = CLR ? '0 : wrCmd.data;

    // Bypass: in-flight data replaces stale register contents on an address match
    assign rd_data_b  = addrHit(effValid, wrCmd.addr, rd_addr_b) ? wrCmd.data : rf_outB;
    assign rd_data_a  = effValid ? wrCmd.data : rf_outA;
    assign rd_stall_a = rd_valid_a && effValid && (rd_addr_a != wrCmd.addr);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table plus randomized traffic,
// all checked against a cycle-level reference model and a register-file model.
module tb_rf_write_arbiter;

    localparam int unsigned N = 3;

    logic            CLK;
    logic            CLR;
    logic [N-1:0]    req_valid;
    logic [4*N-1:0]  req_addr;
    logic [32*N-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            rd_valid_a;
    logic [3:0]      rd_addr_a;
    logic [3:0]      rd_addr_b;
    logic [31:0]     rd_data_a;
    logic [31:0]     rd_data_b;
    logic            rd_stall_a;
    logic [3:0]      rf_addressA;
    logic [3:0]      rf_addressB;
    logic [31:0]     rf_inputData;
    logic            rf_RW;
    logic [31:0]     rf_outA;
    logic [31:0]     rf_outB;

    logic [31:0] rfMem [16];

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          mLast;
    logic        mKnown;
    logic        mAfterClr;
    logic        mPendV;
    logic [3:0]  mPendA;
    logic [31:0] mPendD;
    logic [31:0] mMem [16];

    typedef struct {
        logic        clr;
        logic [2:0]  valid;
        logic [11:0] addr;
        logic [95:0] data;
        logic        rdValid;
        logic [3:0]  rdA;
        logic [3:0]  rdB;
        logic        chkReady;
        logic [2:0]  expReady;
        logic        expRW;
        logic [3:0]  expAddrA;
        logic        expStall;
        logic        chkData;
        logic [31:0] expRd;
    } vec_t;

    vec_t vecs[$];

    rf_write_arbiter #(.N_REQ(N)) dut (
        .CLK          (CLK),
        .CLR          (CLR),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rd_valid_a   (rd_valid_a),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .rd_data_a    (rd_data_a),
        .rd_data_b    (rd_data_b),
        .rd_stall_a   (rd_stall_a),
        .rf_addressA  (rf_addressA),
        .rf_addressB  (rf_addressB),
        .rf_inputData (rf_inputData),
        .rf_RW        (rf_RW),
        .rf_outA      (rf_outA),
        .rf_outB      (rf_outB)
    );

    assign rf_outA = rfMem[rf_addressA];
    assign rf_outB = rfMem[rf_addressB];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic clr, input logic [2:0] v, input logic [11:0] a,
                                input logic [95:0] d, input logic rv, input logic [3:0] ra,
                                input logic [3:0] rb, input logic cr, input logic [2:0] er,
                                input logic ew, input logic [3:0] ea, input logic es,
                                input logic cd, input logic [31:0] ed);
        vec_t t;
        t.clr = clr; t.valid = v; t.addr = a; t.data = d;
        t.rdValid = rv; t.rdA = ra; t.rdB = rb;
        t.chkReady = cr; t.expReady = er; t.expRW = ew; t.expAddrA = ea; t.expStall = es;
        t.chkData = cd; t.expRd = ed;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        CLR        = v.clr;
        req_valid  = v.valid;
        req_addr   = v.addr;
        req_data   = v.data;
        rd_valid_a = v.rdValid;
        rd_addr_a  = v.rdA;
        rd_addr_b  = v.rdB;
    endtask

    // One clock: check at negedge against model (and table row), update at posedge
    task automatic step(input vec_t v, input logic useTab);
        logic [N-1:0] expG;
        int           g;
        int           i;
        logic         pcWin;
        logic         eff;
        logic         sw;
        logic [3:0]   sa;
        logic [31:0]  sd;
        @(negedge CLK);
        g     = -1;
        pcWin = 1'b0;
`ifdef RF_ARB_PC_PRIORITY_EN
        for (int p = 0; p < int'(N); p++)
            if (g < 0 && req_valid[p] && req_addr[4*p +: 4] == 4'hF) begin
                g     = p;
                pcWin = 1'b1;
            end
`endif
        for (int k = 1; k <= int'(N); k++) begin
            i = (mLast + k) % int'(N);
            if (g < 0 && req_valid[i]) g = i;
        end
        expG = '0;
        if (g >= 0) expG[g] = 1'b1;
        eff = mPendV && !CLR;

        if (mKnown && !CLR) chk("req_ready", 32'(req_ready), 32'(expG));
        chk("rf_RW", 32'(rf_RW), 32'(eff));
        chk("rf_addressA", 32'(rf_addressA), 32'(eff ? mPendA : rd_addr_a));
        chk("rf_addressB", 32'(rf_addressB), 32'(rd_addr_b));
        if (eff) chk("rf_inputData", rf_inputData, mPendD);
        else if (CLR || mAfterClr) chk("rf_inputData_rst", rf_inputData, 32'h0);
        chk("rd_stall_a", 32'(rd_stall_a), 32'(rd_valid_a && eff && (rd_addr_a != mPendA)));
        chk("rd_data_b", rd_data_b, (eff && rd_addr_b == mPendA) ? mPendD : mMem[rd_addr_b]);
        if (!eff || rd_addr_a == mPendA)
            chk("rd_data_a", rd_data_a, eff ? mPendD : mMem[rd_addr_a]);

        if (useTab) begin
            if (v.chkReady) chk("tab_ready", 32'(req_ready), 32'(v.expReady));
            chk("tab_RW", 32'(rf_RW), 32'(v.expRW));
            chk("tab_addressA", 32'(rf_addressA), 32'(v.expAddrA));
            chk("tab_stall", 32'(rd_stall_a), 32'(v.expStall));
            if (v.chkData) begin
                chk("tab_rd_data_a", rd_data_a, v.expRd);
                chk("tab_rd_data_b", rd_data_b, v.expRd);
            end
        end

        sw = rf_RW;
        sa = rf_addressA;
        sd = rf_inputData;
        @(posedge CLK);
        if (sw) rfMem[sa] = sd;
        mAfterClr = CLR;
        if (CLR) begin
            mPendV = 1'b0;
            mLast  = int'(N) - 1;
            mKnown = 1'b1;
        end else begin
            if (mPendV) mMem[mPendA] = mPendD;
            if (g >= 0) begin
                mPendV = 1'b1;
                mPendA = req_addr[4*g +: 4];
                mPendD = req_data[32*g +: 32];
                if (!pcWin) mLast = g;
            end else begin
                mPendV = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        logic [95:0] d0;
        logic [11:0] a0;
        vec_t        r;

        for (int k = 0; k < 16; k++) begin
            rfMem[k] = 32'hA0A0_0000 | 32'(k);
            mMem[k]  = 32'hA0A0_0000 | 32'(k);
        end
        mLast = int'(N) - 1; mKnown = 1'b0; mAfterClr = 1'b0;
        mPendV = 1'b0; mPendA = '0; mPendD = '0;
        CLR = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        rd_valid_a = 1'b0; rd_addr_a = '0; rd_addr_b = '0;

        d0 = {32'h0000_3333, 32'h0000_2222, 32'h0000_1111};
        a0 = {4'd3, 4'd2, 4'd1};
        // reset held two cycles with all requesters valid
        vecs.push_back(mk(1, 3'b111, a0, d0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b111, a0, d0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
        // fairness: 0,1,2,0,1,2 with rf_addressA trailing by a cycle
        vecs.push_back(mk(0, 3'b111, a0, d0, 0, 0, 0, 1, 3'b001, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b111, a0, d0, 0, 0, 0, 1, 3'b010, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3'b111, a0, d0, 0, 0, 0, 1, 3'b100, 1, 2, 0, 0, 0));
        vecs.push_back(mk(0, 3'b111, a0, d0, 0, 0, 0, 1, 3'b001, 1, 3, 0, 0, 0));
        vecs.push_back(mk(0, 3'b111, a0, d0, 0, 0, 0, 1, 3'b010, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3'b111, a0, d0, 0, 0, 0, 1, 3'b100, 1, 2, 0, 0, 0));
        // read of R7 while R3 is written stalls, then proceeds
        vecs.push_back(mk(0, 3'b000, a0, d0, 1, 7, 0, 1, 3'b000, 1, 3, 1, 0, 0));
        vecs.push_back(mk(0, 3'b000, a0, d0, 1, 7, 0, 1, 3'b000, 0, 7, 0, 0, 0));
        // bypass of R5 = DEADBEEF from requester 1
        vecs.push_back(mk(0, 3'b010, {4'd0, 4'd5, 4'd0}, {32'h0, 32'hDEADBEEF, 32'h0},
                          0, 0, 0, 1, 3'b010, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b000, a0, d0, 1, 5, 5, 1, 3'b000, 1, 5, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk(0, 3'b000, a0, d0, 1, 5, 5, 1, 3'b000, 0, 5, 0, 1, 32'hDEADBEEF));
        // stall scenario from a fresh write of R3
        vecs.push_back(mk(0, 3'b001, {4'd0, 4'd0, 4'd3}, d0, 0, 0, 0, 1, 3'b001, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b000, a0, d0, 1, 7, 0, 1, 3'b000, 1, 3, 1, 0, 0));
        vecs.push_back(mk(0, 3'b000, a0, d0, 1, 7, 0, 1, 3'b000, 0, 7, 0, 0, 0));
        // mid-operation reset discards the pending R2 write
        vecs.push_back(mk(0, 3'b100, {4'd2, 4'd0, 4'd0}, {32'h1, 32'h0, 32'h0},
                          0, 0, 0, 1, 3'b100, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, a0, d0, 0, 2, 2, 0, 3'b000, 0, 2, 0, 1, 32'h0000_2222));
        vecs.push_back(mk(0, 3'b000, a0, d0, 0, 2, 2, 1, 3'b000, 0, 2, 0, 1, 32'h0000_2222));
        // same register in consecutive grants: later write wins
        vecs.push_back(mk(0, 3'b011, {4'd0, 4'd9, 4'd9}, {32'h0, 32'h22, 32'h11},
                          0, 0, 0, 1, 3'b001, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b011, {4'd0, 4'd9, 4'd9}, {32'h0, 32'h22, 32'h11},
                          0, 0, 0, 1, 3'b010, 1, 9, 0, 0, 0));
        vecs.push_back(mk(0, 3'b000, a0, d0, 0, 9, 9, 1, 3'b000, 1, 9, 0, 1, 32'h22));
        vecs.push_back(mk(0, 3'b000, a0, d0, 0, 9, 9, 1, 3'b000, 0, 9, 0, 1, 32'h22));
        // a lone requester holding valid is granted every cycle
        vecs.push_back(mk(0, 3'b100, {4'd4, 4'd0, 4'd0}, d0, 0, 0, 0, 1, 3'b100, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b100, {4'd4, 4'd0, 4'd0}, d0, 0, 0, 0, 1, 3'b100, 1, 4, 0, 0, 0));
        vecs.push_back(mk(0, 3'b100, {4'd4, 4'd0, 4'd0}, d0, 0, 0, 0, 1, 3'b100, 1, 4, 0, 0, 0));

        @(posedge CLK);
        #1;
        foreach (vecs[j]) begin
            apply(vecs[j]);
            step(vecs[j], 1'b1);
        end

        // randomized traffic checked only against the reference model
        for (int c = 0; c < 400; c++) begin
            r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            r.clr   = ($urandom_range(0, 39) == 0);
            r.valid = 3'($urandom);
            for (int q = 0; q < int'(N); q++) begin
                r.addr[4*q +: 4]  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 7));
                r.data[32*q +: 32] = $urandom;
            end
            r.rdValid = 1'($urandom);
            r.rdA     = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 7));
            r.rdB     = 4'($urandom_range(0, 15));
            apply(r);
            step(r, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single write port of the 16×32 register file among N_REQ write-back requesters (ALU result, load data, link/PC update) using round-robin arbitration. It owns the register file's port-A address, write data and RW lines. While a write is in flight, it steals port A from the read path and signals a stall, except when a same-address bypass can serve the read.

## Interface
- N_REQ, 3: number of write requesters (2..8).
- CLK  in  1  clock; register file writes on the same rising edge.
- CLR  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester write request.
- req_addr  in  4*N_REQ  destination register; requester i occupies bits [4i+3:4i].
- req_data  in  32*N_REQ  write data; requester i occupies bits [32i+31:32i].
- req_ready  out  N_REQ  one-hot grant; the request is accepted when valid & ready.
- rd_valid_a  in  1  read-port-A request this cycle.
- rd_addr_a, rd_addr_b  in  4  read addresses.
- rd_data_a, rd_data_b  out  32  read results after bypass.
- rd_stall_a  out  1  port-A read not served this cycle.
- rf_addressA, rf_addressB  out  4  to the register file.
- rf_inputData  out  32  to the register file.
- rf_RW  out  1  register-file write enable (1 = write).
- rf_outA, rf_outB  in  32  register-file read data.

## Operation
**Arbitration (combinational)**
- Scan requesters starting at (last_grant+1) mod N_REQ.
- Grant the first one with req_valid=1; req_ready is one-hot or zero.
- Grant never depends on req_ready.

**Write stage (registered)**
- On acceptance, latch wr_valid=1, wr_addr, wr_data.
- Set last_grant to the granted index.
- With no acceptance, wr_valid=0.
- The register file accepts every cycle, so the stage never backs up and req_ready needs no downstream term.

**Port mux**
- rf_RW = wr_valid.
- rf_addressA = wr_valid ? wr_addr : rd_addr_a.
- rf_addressB = rd_addr_b.
- rf_inputData = wr_data.

**Bypass**
- rd_data_b = (wr_valid && rd_addr_b==wr_addr) ? wr_data : rf_outB.
- rd_data_a:
  - If !wr_valid: rf_outA.
  - If wr_valid and rd_addr_a==wr_addr: wr_data.
  - Otherwise: don't-care. This is the stall case.

**Stall**
- rd_stall_a = rd_valid_a && wr_valid && (rd_addr_a != wr_addr).

**Boundary cases**
- Two requesters targeting the same register in consecutive cycles: both writes happen in grant order; the later one wins.
- R15 receives no special treatment unless the Configuration macro is defined.
- A single requester holding valid continuously is granted every cycle.
- With all requesters valid, each is granted exactly once per N_REQ cycles.

## Timing
- Request accepted in cycle N → rf_RW=1 with its address and data during N+1 → register updated at the edge ending N+1.
- A read of that register in N+2 or later sees the new value from rf_outA/B.
- A read in N+1 sees it via bypass.
- Reset values while CLR=1 and in the cycle after:
  - wr_valid=0, rf_RW=0, rf_inputData=0.
  - last_grant=N_REQ-1, so requester 0 has first priority.
  - rd_stall_a=0.
  - req_ready is still computed but is ignored during reset.
- CLR asserted mid-operation: a pending write-stage entry is discarded and never reaches the register file. Requests accepted in a CLR cycle are dropped.

## Configuration
- RF_ARB_PC_PRIORITY_EN defined:
  - Any valid request with address 4'hF is granted ahead of the round-robin order; the lowest index wins among several such requests.
  - last_grant is not updated by such a grant.
- Undefined: pure round-robin.

## Structure
- Shared package rf_pkg holds:
  - RF_ADDR_W=4, RF_DATA_W=32, RF_PC_ADDR=4'hF.
  - The write-command struct typedef (valid, addr, data).
- One sub-module, rr_arbiter: a parameterised N-way round-robin grant with a last-grant pointer. It is reusable for memory-port sharing.

## Test plan
- Reset: hold CLR 2 cycles with all req_valid=1 → rf_RW=0 throughout; the first grant after release is req_ready=3'b001.
- Fairness: all 3 valid for 6 cycles → grants 0,1,2,0,1,2; rf_addressA follows each req_addr one cycle later.
- Bypass: requester 1 writes R5=32'hDEADBEEF in cycle N; rd_addr_a=rd_addr_b=5 in N+1 → both outputs DEADBEEF, rd_stall_a=0.
- Stall: write R3 accepted in N; rd_valid_a=1, rd_addr_a=7 in N+1 → rd_stall_a=1 and rf_addressA=3; in N+2 with no write, stall=0 and rf_addressA=7.
- Mid-op reset: accept write R2=32'h1 in N; CLR=1 in N+1 → rf_RW=0 in N+1; R2 keeps its old value.
- With RF_ARB_PC_PRIORITY_EN: requesters 0 (R4) and 2 (R15) valid with last_grant=2 → requester 2 granted first, then requester 0.
